dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 41 ++++
 rtl/dmem_arbiter.sv | 117 +++++++++++
 tb/tb_dmem_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the load-buffer, ROB-commit and memory-command signals around dmem_arbiter.
// The arbiter uses the slave view; whatever drives requests and models memory uses master.
interface dmem_arbiter_if #(
    parameter int XLEN        = 32,
    parameter int ROB_TAG_LEN = 5
);
    logic                   ld_req;
    logic [XLEN-1:0]        ld_addr;
    logic [ROB_TAG_LEN-1:0] ld_rob_tag;
    logic                   st_req;
    logic [XLEN-1:0]        st_addr;
    logic [XLEN-1:0]        st_data;
    logic                   ld_grant;
    logic                   st_grant;
    logic                   mem_busy;
    logic                   mem_req;
    logic                   mem_we;
    logic [XLEN-1:0]        mem_addr;
    logic [XLEN-1:0]        mem_wdata;
    logic                   mem_ready;
    logic                   mem_rsp_valid;
    logic [XLEN-1:0]        mem_rsp_data;
    logic                   ld_done;
    logic [XLEN-1:0]        ld_done_data;
    logic [ROB_TAG_LEN-1:0] ld_done_tag;
    logic                   st_done;

    modport slave (
        input  ld_req, ld_addr, ld_rob_tag, st_req, st_addr, st_data,
        input  mem_ready, mem_rsp_valid, mem_rsp_data,
        output ld_grant, st_grant, mem_busy, mem_req, mem_we, mem_addr, mem_wdata,
        output ld_done, ld_done_data, ld_done_tag, st_done
    );

    modport master (
        output ld_req, ld_addr, ld_rob_tag, st_req, st_addr, st_data,
        output mem_ready, mem_rsp_valid, mem_rsp_data,
        input  ld_grant, st_grant, mem_busy, mem_req, mem_we, mem_addr, mem_wdata,
        input  ld_done, ld_done_data, ld_done_tag, st_done
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-outstanding data-memory arbiter between the load buffer and ROB commit stores.
// Stores have priority; a bounded starvation counter eventually forces a waiting load through.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = 32,
    parameter int ROB_TAG_LEN  = 5
) (
    input logic           clock,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       starve_cnt;
    logic                   we_q;
    logic [XLEN-1:0]        addr_q;
    logic [XLEN-1:0]        wdata_q;
    logic [XLEN-1:0]        rdata_q;
    logic [ROB_TAG_LEN-1:0] tag_q;
    logic                   req_q;
    logic                   busy_q;
    logic                   ld_done_q;
    logic                   st_done_q;

    logic idle;
    logic ld_win;
    logic grant_ld;
    logic grant_st;

    // NOTE: grants are combinational, so they are qualified by reset explicitly;
    // the registers alone cannot force them low while reset is asserted.
    always_comb begin
        idle     = reset && (state == S_IDLE);
        // A load wins when it is alone or once stores have used up the starvation allowance.
        ld_win   = bus.ld_req && (!bus.st_req || (starve_cnt == CNT_MAX));
        grant_ld = idle && ld_win;
        grant_st = idle && bus.st_req && !ld_win;
    end

    // NOTE: every register here is written with <= so all state updates see pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            starve_cnt <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            tag_q      <= '0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            ld_done_q  <= 1'b0;
            st_done_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Only a store that overtakes a waiting load counts as starvation.
                    if (grant_st && bus.ld_req) begin
                        starve_cnt <= (starve_cnt == CNT_MAX) ? CNT_MAX : starve_cnt + CNT_W'(1);
                    end else begin
                        starve_cnt <= '0;
                    end
                    if (grant_ld || grant_st) begin
                        we_q    <= grant_st;
                        addr_q  <= grant_st ? bus.st_addr : bus.ld_addr;
                        wdata_q <= grant_st ? bus.st_data : '0;
                        tag_q   <= grant_st ? '0 : bus.ld_rob_tag;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.mem_ready) begin
                        req_q <= 1'b0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        rdata_q   <= bus.mem_rsp_data;
                        ld_done_q <= !we_q;
                        st_done_q <= we_q;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    ld_done_q <= 1'b0;
                    st_done_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ld_grant     = grant_ld;
    assign bus.st_grant     = grant_st;
    assign bus.mem_busy     = busy_q;
    assign bus.mem_req      = req_q;
    assign bus.mem_we       = we_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.ld_done      = ld_done_q;
    assign bus.ld_done_data = rdata_q;
    assign bus.ld_done_tag  = tag_q;
    assign bus.st_done      = st_done_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_dmem_arbiter;
    localparam int LIMIT = 4;
    localparam int XLEN  = 32;
    localparam int TAGW  = 5;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    dmem_arbiter_if #(.XLEN(XLEN), .ROB_TAG_LEN(TAGW)) bus ();

    dmem_arbiter #(
        .STARVE_LIMIT(LIMIT),
        .XLEN        (XLEN),
        .ROB_TAG_LEN (TAGW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    function automatic logic [107:0] outs();
        return {bus.ld_grant, bus.st_grant, bus.mem_busy, bus.mem_req, bus.mem_we,
                bus.ld_done, bus.st_done, bus.mem_addr, bus.mem_wdata,
                bus.ld_done_data, bus.ld_done_tag};
    endfunction

    task automatic idle_inputs();
        bus.ld_req        = 1'b0;
        bus.ld_addr       = '0;
        bus.ld_rob_tag    = '0;
        bus.st_req        = 1'b0;
        bus.st_addr       = '0;
        bus.st_data       = '0;
        bus.mem_ready     = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
    endtask

    // Leaves the bench just after a falling edge in the first IDLE cycle after reset.
    task automatic apply_reset();
        @(negedge clock);
        idle_inputs();
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b0;
        bus.ld_req = 1'b1; bus.st_req = 1'b1; bus.mem_ready = 1'b1; bus.mem_rsp_valid = 1'b1;
        bus.ld_addr = 32'h1234; bus.st_addr = 32'h5678; bus.st_data = 32'h9abc;
        #1;
        total++;
        if (outs() !== '0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0", outs());
        end
        @(negedge clock); #1;
        total++;
        if (outs() !== '0) begin
            bad++; $display("FAIL reset_held got=%h want=0", outs());
        end
        idle_inputs();
        reset = 1'b1;
    endtask

    task automatic test_single_load();
        apply_reset();
        bus.ld_req = 1'b1; bus.ld_addr = 32'h100; bus.ld_rob_tag = 5'd3; bus.mem_ready = 1'b1;
        #1;
        total++;
        if ({bus.ld_grant, bus.st_grant} !== 2'b10) begin
            bad++; $display("FAIL load_grant got=%b want=10", {bus.ld_grant, bus.st_grant});
        end
        @(negedge clock);
        bus.ld_req = 1'b0;
        #1;
        total++;
        if ({bus.mem_req, bus.mem_we, bus.mem_busy, bus.mem_addr, bus.mem_wdata} !== {3'b101, 32'h100, 32'h0}) begin
            bad++; $display("FAIL load_issue got=%b/%h/%h want=101/100/0",
                            {bus.mem_req, bus.mem_we, bus.mem_busy}, bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clock);
        bus.mem_ready = 1'b0; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hDEADBEEF;
        #1;
        total++;
        if ({bus.mem_req, bus.mem_busy, bus.ld_done} !== 3'b010) begin
            bad++; $display("FAIL load_wait got=%b want=010", {bus.mem_req, bus.mem_busy, bus.ld_done});
        end
        @(negedge clock);
        bus.mem_rsp_valid = 1'b0;
        #1;
        total++;
        if ({bus.ld_done, bus.st_done, bus.ld_done_data, bus.ld_done_tag} !== {2'b10, 32'hDEADBEEF, 5'd3}) begin
            bad++; $display("FAIL load_done got=%b/%h/%0d want=10/deadbeef/3",
                            {bus.ld_done, bus.st_done}, bus.ld_done_data, bus.ld_done_tag);
        end
        @(negedge clock); #1;
        total++;
        if ({bus.ld_done, bus.mem_busy} !== 2'b00) begin
            bad++; $display("FAIL load_back_idle got=%b want=00", {bus.ld_done, bus.mem_busy});
        end
    endtask

    task automatic test_store_priority();
        apply_reset();
        bus.ld_req = 1'b1; bus.ld_addr = 32'h140; bus.ld_rob_tag = 5'd7;
        bus.st_req = 1'b1; bus.st_addr = 32'h200; bus.st_data = 32'h55;
        #1;
        total++;
        if ({bus.ld_grant, bus.st_grant} !== 2'b01) begin
            bad++; $display("FAIL prio_grant got=%b want=01", {bus.ld_grant, bus.st_grant});
        end
        @(negedge clock);
        bus.st_req = 1'b0; bus.mem_ready = 1'b1;
        #1;
        total++;
        if ({bus.mem_req, bus.mem_we, bus.ld_grant, bus.mem_addr, bus.mem_wdata} !== {3'b110, 32'h200, 32'h55}) begin
            bad++; $display("FAIL prio_store_issue got=%b/%h/%h want=110/200/55",
                            {bus.mem_req, bus.mem_we, bus.ld_grant}, bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clock);
        bus.mem_ready = 1'b0; bus.mem_rsp_valid = 1'b1;
        @(negedge clock);
        bus.mem_rsp_valid = 1'b0;
        #1;
        total++;
        if ({bus.st_done, bus.ld_done} !== 2'b10) begin
            bad++; $display("FAIL prio_store_done got=%b want=10", {bus.st_done, bus.ld_done});
        end
        @(negedge clock); #1;
        total++;
        if ({bus.ld_grant, bus.st_grant} !== 2'b10) begin
            bad++; $display("FAIL prio_load_next got=%b want=10", {bus.ld_grant, bus.st_grant});
        end
        @(negedge clock);
        bus.ld_req = 1'b0;
        #1;
        total++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b10, 32'h140, 32'h0}) begin
            bad++; $display("FAIL prio_load_issue got=%b/%h/%h want=10/140/0",
                            {bus.mem_req, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
        end
    endtask

    // Both requesters always asserted with an instant memory: one grant every 4 cycles,
    // and every fifth grant must go to the load.
    task automatic test_starvation();
        apply_reset();
        bus.ld_req = 1'b1; bus.ld_addr = 32'h10; bus.ld_rob_tag = 5'd2;
        bus.st_req = 1'b1; bus.st_addr = 32'h20; bus.st_data = 32'h30;
        bus.mem_ready = 1'b1; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h77;
        for (int c = 0; c < 40; c++) begin
            int  slot;
            int  gidx;
            logic is_ld;
            if (c != 0) @(negedge clock);
            #1;
            slot  = c % 4;
            gidx  = c / 4;
            is_ld = (gidx % (LIMIT + 1)) == LIMIT;
            total++;
            if ({bus.ld_grant, bus.st_grant, bus.mem_busy} !== {slot == 0 && is_ld, slot == 0 && !is_ld, slot != 0}) begin
                bad++; $display("FAIL starve_c%0d got=%b want=%b", c, {bus.ld_grant, bus.st_grant, bus.mem_busy},
                                {slot == 0 && is_ld, slot == 0 && !is_ld, slot != 0});
            end
            if (slot == 1) begin
                total++;
                if (bus.mem_we !== !is_ld) begin
                    bad++; $display("FAIL starve_we_c%0d got=%b want=%b", c, bus.mem_we, !is_ld);
                end
            end
        end
    endtask

    task automatic test_ready_stall();
        apply_reset();
        bus.ld_req = 1'b1; bus.ld_addr = 32'hABC0; bus.ld_rob_tag = 5'd9;
        #1;
        total++;
        if (bus.ld_grant !== 1'b1) begin
            bad++; $display("FAIL stall_grant got=%b want=1", bus.ld_grant);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            bus.ld_req = 1'b0; bus.st_req = 1'b1; bus.st_addr = $urandom; bus.st_data = $urandom;
            #1;
            total++;
            if ({bus.mem_req, bus.mem_busy, bus.mem_we, bus.ld_grant, bus.st_grant, bus.mem_addr} !== {5'b11000, 32'hABC0}) begin
                bad++; $display("FAIL stall_c%0d got=%b/%h want=11000/abc0", c,
                                {bus.mem_req, bus.mem_busy, bus.mem_we, bus.ld_grant, bus.st_grant}, bus.mem_addr);
            end
        end
        @(negedge clock);
        bus.st_req = 1'b0; bus.mem_ready = 1'b1;
        @(negedge clock);
        bus.mem_ready = 1'b0; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hCAFE0001;
        @(negedge clock);
        bus.mem_rsp_valid = 1'b0;
        #1;
        total++;
        if ({bus.ld_done, bus.ld_done_data, bus.ld_done_tag} !== {1'b1, 32'hCAFE0001, 5'd9}) begin
            bad++; $display("FAIL stall_done got=%b/%h/%0d want=1/cafe0001/9",
                            bus.ld_done, bus.ld_done_data, bus.ld_done_tag);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.ld_req = 1'b1; bus.ld_addr = 32'h300; bus.ld_rob_tag = 5'd5; bus.mem_ready = 1'b1;
        @(negedge clock);
        bus.ld_req = 1'b0;
        @(negedge clock);
        bus.mem_ready = 1'b0;
        #1;
        total++;
        if ({bus.mem_busy, bus.mem_req} !== 2'b10) begin
            bad++; $display("FAIL midrst_in_wait got=%b want=10", {bus.mem_busy, bus.mem_req});
        end
        #2;
        reset = 1'b0;
        bus.ld_req = 1'b1; bus.st_req = 1'b1;
        #1;
        total++;
        if (outs() !== '0) begin
            bad++; $display("FAIL midrst_async got=%h want=0", outs());
        end
        @(negedge clock); #1;
        reset = 1'b1;
        bus.ld_req = 1'b0; bus.st_req = 1'b0;
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h1234;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock); #1;
            total++;
            if ({bus.ld_done, bus.st_done, bus.mem_busy, bus.mem_req} !== 4'b0000) begin
                bad++; $display("FAIL midrst_after_c%0d got=%b want=0000", c,
                                {bus.ld_done, bus.st_done, bus.mem_busy, bus.mem_req});
            end
        end
        bus.mem_rsp_valid = 1'b0;
    endtask

    task automatic test_idle_rsp();
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            if (c != 0) @(negedge clock);
            bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = $urandom;
            #1;
            total++;
            if ({bus.ld_done, bus.st_done, bus.mem_busy, bus.mem_req, bus.ld_grant, bus.st_grant} !== 6'b0) begin
                bad++; $display("FAIL idle_rsp_c%0d got=%b want=000000", c,
                                {bus.ld_done, bus.st_done, bus.mem_busy, bus.mem_req, bus.ld_grant, bus.st_grant});
            end
        end
        @(negedge clock);
        bus.mem_rsp_valid = 1'b0;
        bus.ld_req = 1'b1; bus.ld_addr = 32'h44; bus.ld_rob_tag = 5'd1;
        #1;
        total++;
        if (bus.ld_grant !== 1'b1) begin
            bad++; $display("FAIL idle_rsp_still_idle got=%b want=1", bus.ld_grant);
        end
        @(negedge clock);
        bus.ld_req = 1'b0;
        #1;
        total++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h44}) begin
            bad++; $display("FAIL idle_rsp_issue got=%b/%h want=1/44", bus.mem_req, bus.mem_addr);
        end
    endtask

    // Random requesters (held until granted), random memory handshakes, checked every cycle
    // against a model that tracks the outstanding transaction and the store-over-load streak.
    task automatic test_random();
        int          phase;
        int          streak;
        logic        c_we;
        logic [31:0] c_addr;
        logic [31:0] c_wdata;
        logic [31:0] c_rdata;
        logic [4:0]  c_tag;
        logic        e_ldg;
        logic        e_stg;
        logic        prev_ldg;
        logic        prev_stg;
        logic [70:0] exp_v;
        logic [70:0] act_v;
        apply_reset();
        phase = 0; streak = 0;
        c_we = 1'b0; c_addr = '0; c_wdata = '0; c_rdata = '0; c_tag = '0;
        prev_ldg = 1'b0; prev_stg = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (cyc != 0) @(negedge clock);
            if (!bus.ld_req || prev_ldg) begin
                bus.ld_req = ($urandom_range(0, 2) == 0);
                bus.ld_addr = $urandom; bus.ld_rob_tag = 5'($urandom);
            end
            if (!bus.st_req || prev_stg) begin
                bus.st_req = ($urandom_range(0, 2) == 0);
                bus.st_addr = $urandom; bus.st_data = $urandom;
            end
            bus.mem_ready     = ($urandom_range(0, 2) != 0);
            bus.mem_rsp_valid = ($urandom_range(0, 2) == 0);
            bus.mem_rsp_data  = $urandom;
            #1;
            e_ldg = (phase == 0) && bus.ld_req && (!bus.st_req || streak == LIMIT);
            e_stg = (phase == 0) && bus.st_req && !e_ldg;
            exp_v = {e_ldg, e_stg, phase == 1, phase != 0, phase == 3 && !c_we, phase == 3 && c_we,
                     c_we, c_addr, c_wdata};
            act_v = {bus.ld_grant, bus.st_grant, bus.mem_req, bus.mem_busy, bus.ld_done, bus.st_done,
                     bus.mem_we, bus.mem_addr, bus.mem_wdata};
            total++;
            if (act_v !== exp_v) begin
                bad++; $display("FAIL random_c%0d got=%h want=%h", cyc, act_v, exp_v);
            end
            if (phase == 3 && !c_we) begin
                total++;
                if ({bus.ld_done_data, bus.ld_done_tag} !== {c_rdata, c_tag}) begin
                    bad++; $display("FAIL random_ld_data_c%0d got=%h/%0d want=%h/%0d", cyc,
                                    bus.ld_done_data, bus.ld_done_tag, c_rdata, c_tag);
                end
            end
            case (phase)
                0: begin
                    if (e_ldg || e_stg) begin
                        c_we    = e_stg;
                        c_addr  = e_stg ? bus.st_addr : bus.ld_addr;
                        c_wdata = e_stg ? bus.st_data : 32'h0;
                        if (e_ldg) c_tag = bus.ld_rob_tag;
                        phase   = 1;
                    end
                    streak = (e_stg && bus.ld_req) ? ((streak < LIMIT) ? streak + 1 : LIMIT) : 0;
                end
                1: if (bus.mem_ready) phase = 2;
                2: if (bus.mem_rsp_valid) begin c_rdata = bus.mem_rsp_data; phase = 3; end
                default: phase = 0;
            endcase
            prev_ldg = e_ldg;
            prev_stg = e_stg;
        end
        @(negedge clock);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_load();
        test_store_priority();
        test_starvation();
        test_ready_stall();
        test_reset_mid();
        test_idle_rsp();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
